// File: rtl/tk1_sec_mon_pkg.sv
// Shared constants for the security monitor: register map, identity words,
// firmware RAM bounds and violation cause codes.
package tk1_sec_mon_pkg;

  localparam logic [7:0] ADDR_NAME0       = 8'h00;
  localparam logic [7:0] ADDR_NAME1       = 8'h01;
  localparam logic [7:0] ADDR_VERSION     = 8'h02;
  localparam logic [7:0] ADDR_CTRL        = 8'h08;
  localparam logic [7:0] ADDR_STATUS      = 8'h09;
  localparam logic [7:0] ADDR_VIOL_ADDR   = 8'h0a;
  localparam logic [7:0] ADDR_VIOL_COUNT  = 8'h0b;
  localparam logic [7:0] ADDR_REGION_BASE = 8'h10;
  localparam logic [7:0] ADDR_REGION_END  = 8'h2f;

  localparam logic [1:0] REG_FIRST = 2'd0;
  localparam logic [1:0] REG_LAST  = 2'd1;
  localparam logic [1:0] REG_PERM  = 2'd2;

  localparam int PERM_EXEC_BIT  = 0;
  localparam int PERM_READ_BIT  = 1;
  localparam int PERM_WRITE_BIT = 2;

  localparam logic [31:0] CORE_NAME0   = 32'h746b3120;  // "tk1 "
  localparam logic [31:0] CORE_NAME1   = 32'h736d6f6e;  // "smon"
  localparam logic [31:0] CORE_VERSION = 32'h00000001;

  localparam logic [31:0] FW_RAM_FIRST   = 32'hd0000000;
  localparam logic [31:0] FW_RAM_LAST    = 32'hd00007ff;
  localparam logic [1:0]  RAM_WINDOW_TAG = 2'b01;

  typedef enum logic [2:0] {
    CAUSE_NONE         = 3'd0,
    CAUSE_FW_EXEC      = 3'd1,
    CAUSE_RAM_OOB      = 3'd2,
    CAUSE_REGION_EXEC  = 3'd3,
    CAUSE_REGION_READ  = 3'd4,
    CAUSE_REGION_WRITE = 3'd5
  } cause_e;

endpackage

// File: rtl/tk1_sec_mon_region.sv
// One programmable monitor region: FIRST/LAST/PERM registers plus an
// inclusive address-range comparator and per-access-type deny flags.
module tk1_sec_mon_region
  import tk1_sec_mon_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en_i,
  input  logic [1:0]  wr_sel_i,
  input  logic [31:0] wr_data_i,
  input  logic [31:0] cpu_addr_i,
  output logic [31:0] first_o,
  output logic [31:0] last_o,
  output logic [2:0]  perm_o,
  output logic        match_o,
  output logic        deny_exec_o,
  output logic        deny_read_o,
  output logic        deny_write_o
);

  logic [31:0] first_q, first_d;
  logic [31:0] last_q, last_d;
  logic [2:0]  perm_q, perm_d;

  always_comb begin
    first_d = first_q;
    last_d  = last_q;
    perm_d  = perm_q;
    if (wr_en_i) begin
      case (wr_sel_i)
        REG_FIRST: first_d = wr_data_i;
        REG_LAST:  last_d  = wr_data_i;
        REG_PERM:  perm_d  = wr_data_i[2:0];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      first_q <= '0;
      last_q  <= '0;
      perm_q  <= '0;
    end else begin
      first_q <= first_d;
      last_q  <= last_d;
      perm_q  <= perm_d;
    end
  end

  // An inverted range (first > last) can never satisfy both bounds.
  assign match_o      = (cpu_addr_i >= first_q) && (cpu_addr_i <= last_q);
  assign deny_exec_o  = perm_q[PERM_EXEC_BIT];
  assign deny_read_o  = perm_q[PERM_READ_BIT];
  assign deny_write_o = perm_q[PERM_WRITE_BIT];
  assign first_o      = first_q;
  assign last_o       = last_q;
  assign perm_o       = perm_q;

endmodule

// File: rtl/tk1_sec_mon.sv
// Security monitor: checks every CPU access against fixed and programmable
// rules, latches a sticky trap, captures the first violation and blinks a LED.
module tk1_sec_mon
  import tk1_sec_mon_pkg::*;
#(
  parameter int          NUM_REGIONS    = 4,
  parameter int          BLINK_WIDTH    = 24,
  parameter logic [31:0] RAM_MAX_OFFSET = 32'h0001ffff
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_valid,
  input  logic        cpu_instr,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  output logic        force_trap,
  output logic [2:0]  trap_led,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready
);

  logic [1:0]             ctrl_q, ctrl_d;
  logic [7:0]             status_q, status_d;
  logic [31:0]            viol_addr_q, viol_addr_d;
  logic [15:0]            viol_count_q, viol_count_d;
  logic                   force_trap_q, force_trap_d;
  logic                   red_q, red_d;
  logic [BLINK_WIDTH-1:0] blink_q, blink_d;

  logic       reg_wr, enable, lock;
  logic       region_hit;
  logic [2:0] region_idx;
  logic [1:0] region_sel;

  logic [31:0]            reg_first [NUM_REGIONS];
  logic [31:0]            reg_last  [NUM_REGIONS];
  logic [2:0]             reg_perm  [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] reg_match, reg_deny_exec, reg_deny_read, reg_deny_write;
  logic [NUM_REGIONS-1:0] reg_viol;

  logic       is_exec, is_write, is_read;
  logic       fw_exec_hit, ram_oob_hit;
  cause_e     viol_cause;
  logic [3:0] viol_region;
  logic       viol;

  assign reg_wr     = cs && we;
  assign enable     = ctrl_q[0];
  assign lock       = ctrl_q[1];
  assign region_hit = (address >= ADDR_REGION_BASE) && (address <= ADDR_REGION_END);
  assign region_idx = 3'(address[5:2] - 4'd4);
  assign region_sel = address[1:0];

  generate
    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
      tk1_sec_mon_region u_region (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en_i      (reg_wr && !lock && region_hit && (region_idx == 3'(gi))),
        .wr_sel_i     (region_sel),
        .wr_data_i    (write_data),
        .cpu_addr_i   (cpu_addr),
        .first_o      (reg_first[gi]),
        .last_o       (reg_last[gi]),
        .perm_o       (reg_perm[gi]),
        .match_o      (reg_match[gi]),
        .deny_exec_o  (reg_deny_exec[gi]),
        .deny_read_o  (reg_deny_read[gi]),
        .deny_write_o (reg_deny_write[gi])
      );
      assign reg_viol[gi] = reg_match[gi] &&
                            ((is_exec && reg_deny_exec[gi]) ||
                             (is_read && reg_deny_read[gi]) ||
                             (is_write && reg_deny_write[gi]));
    end
  endgenerate

  assign is_exec     = cpu_instr;
  assign is_write    = !cpu_instr && cpu_write;
  assign is_read     = !cpu_instr && !cpu_write;
  assign fw_exec_hit = is_exec && (cpu_addr >= FW_RAM_FIRST) && (cpu_addr <= FW_RAM_LAST);
  assign ram_oob_hit = (cpu_addr[31:30] == RAM_WINDOW_TAG) &&
                       ({2'b00, cpu_addr[29:0]} > RAM_MAX_OFFSET);

  // Fixed rules outrank region rules; descending scan leaves the lowest region.
  always_comb begin
    viol_cause  = CAUSE_NONE;
    viol_region = '0;
    if (cpu_valid) begin
      if (fw_exec_hit) begin
        viol_cause = CAUSE_FW_EXEC;
      end else if (ram_oob_hit) begin
        viol_cause = CAUSE_RAM_OOB;
      end else if (enable) begin
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
          if (reg_viol[i]) begin
            viol_region = 4'(i);
            viol_cause  = is_exec  ? CAUSE_REGION_EXEC :
                          is_write ? CAUSE_REGION_WRITE : CAUSE_REGION_READ;
          end
        end
      end
    end
  end

  assign viol = (viol_cause != CAUSE_NONE);

  always_comb begin
    ctrl_d       = ctrl_q;
    status_d     = status_q;
    viol_addr_d  = viol_addr_q;
    viol_count_d = viol_count_q;
    force_trap_d = force_trap_q || viol;
    blink_d      = '0;
    red_d        = red_q;
    if (reg_wr && !lock && (address == ADDR_CTRL)) begin
      ctrl_d = ctrl_q | write_data[1:0];
    end
    if (viol && !status_q[0]) begin
      status_d    = {viol_region, viol_cause, 1'b1};
      viol_addr_d = cpu_addr;
    end
    if (viol && (viol_count_q != 16'hffff)) begin
      viol_count_d = viol_count_q + 16'd1;
    end
    if (force_trap_q) begin
      blink_d = blink_q + BLINK_WIDTH'(1);
      if (blink_d == '0) begin
        red_d = ~red_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_q       <= '0;
      status_q     <= '0;
      viol_addr_q  <= '0;
      viol_count_q <= '0;
      force_trap_q <= 1'b0;
      red_q        <= 1'b0;
      blink_q      <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      status_q     <= status_d;
      viol_addr_q  <= viol_addr_d;
      viol_count_q <= viol_count_d;
      force_trap_q <= force_trap_d;
      red_q        <= red_d;
      blink_q      <= blink_d;
    end
  end

  assign force_trap = force_trap_q;
  assign trap_led   = force_trap_q ? {red_q, 2'b00} : 3'b000;
  assign ready      = cs;

  always_comb begin
    read_data = '0;
    case (address)
      ADDR_NAME0:      read_data = CORE_NAME0;
      ADDR_NAME1:      read_data = CORE_NAME1;
      ADDR_VERSION:    read_data = CORE_VERSION;
      ADDR_CTRL:       read_data = {30'b0, ctrl_q};
      ADDR_STATUS:     read_data = {24'b0, status_q};
      ADDR_VIOL_ADDR:  read_data = viol_addr_q;
      ADDR_VIOL_COUNT: read_data = {16'b0, viol_count_q};
      default: begin
        if (region_hit) begin
          for (int i = 0; i < NUM_REGIONS; i++) begin
            if (region_idx == 3'(i)) begin
              case (region_sel)
                REG_FIRST: read_data = reg_first[i];
                REG_LAST:  read_data = reg_last[i];
                REG_PERM:  read_data = {29'b0, reg_perm[i]};
                default:   read_data = '0;
              endcase
            end
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_tk1_sec_mon.sv
// Directed bench for tk1_sec_mon; expected values go into a scoreboard queue
// when stimulus is driven and are popped when the DUT output is sampled.
module tb_tk1_sec_mon;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_valid, cpu_instr, cpu_write;
  logic [31:0] cpu_addr;
  logic        force_trap;
  logic [2:0]  trap_led;
  logic        cs, we;
  logic [7:0]  address;
  logic [31:0] write_data, read_data;
  logic        ready;

  int checks = 0;
  int errors = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  tk1_sec_mon #(
    .NUM_REGIONS    (4),
    .BLINK_WIDTH    (4),
    .RAM_MAX_OFFSET (32'h0001ffff)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_valid  (cpu_valid),
    .cpu_instr  (cpu_instr),
    .cpu_write  (cpu_write),
    .cpu_addr   (cpu_addr),
    .force_trap (force_trap),
    .trap_led   (trap_led),
    .cs         (cs),
    .we         (we),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(string tag, logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic observe(logic [31:0] obs);
    string       tag;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
      return;
    end
    tag = tag_q.pop_front();
    e   = exp_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic probe(string tag, logic [31:0] e, logic [31:0] obs);
    expect_val(tag, e);
    observe(obs);
  endtask

  task automatic wr(logic [7:0] a, logic [31:0] d);
    cs = 1'b1; we = 1'b1; address = a; write_data = d;
    tick();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(logic [7:0] a, logic [31:0] e, string tag);
    expect_val(tag, e);
    expect_val({tag, "_ready"}, 32'd1);
    cs = 1'b1; we = 1'b0; address = a;
    #1;
    observe(read_data);
    observe({31'b0, ready});
    cs = 1'b0;
    tick();
  endtask

  task automatic cpu(logic instr, logic wr_en, logic [31:0] a, logic exp_trap, string tag);
    expect_val(tag, {31'b0, exp_trap});
    cpu_valid = 1'b1; cpu_instr = instr; cpu_write = wr_en; cpu_addr = a;
    tick();
    cpu_valid = 1'b0;
    observe({31'b0, force_trap});
  endtask

  task automatic do_reset();
    reset_n = 1'b0; cs = 1'b0; we = 1'b0; cpu_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; cpu_valid = 1'b0; cpu_instr = 1'b0; cpu_write = 1'b0;
    cpu_addr = '0; cs = 1'b0; we = 1'b0; address = '0; write_data = '0;
    do_reset();

    // Reset state and identity
    probe("rst_force_trap", 32'd0, {31'b0, force_trap});
    probe("rst_trap_led", 32'd0, {29'b0, trap_led});
    probe("ready_idle", 32'd0, {31'b0, ready});
    rd(8'h00, 32'h746b3120, "name0");
    rd(8'h01, 32'h736d6f6e, "name1");
    rd(8'h02, 32'h00000001, "version");
    rd(8'h08, 32'd0, "rst_ctrl");
    rd(8'h09, 32'd0, "rst_status");
    rd(8'h0a, 32'd0, "rst_viol_addr");
    rd(8'h0b, 32'd0, "rst_viol_count");
    rd(8'h10, 32'd0, "rst_first0");
    wr(8'h20, 32'hffffffff);
    rd(8'h20, 32'd0, "absent_region4");
    wr(8'h05, 32'hffffffff);
    rd(8'h05, 32'd0, "unmapped_05");
    wr(8'h13, 32'hffffffff);
    rd(8'h13, 32'd0, "unmapped_13");

    // Firmware RAM exec rule and trap latency
    cpu(1'b1, 1'b0, 32'hd0000800, 1'b0, "fw_exec_above_range");
    cpu(1'b0, 1'b0, 32'hd0000004, 1'b0, "fw_data_read_ok");
    expect_val("trap_not_same_cycle", 32'd0);
    expect_val("trap_next_cycle", 32'd1);
    cpu_valid = 1'b1; cpu_instr = 1'b1; cpu_write = 1'b0; cpu_addr = 32'hd0000004;
    #1;
    observe({31'b0, force_trap});
    @(posedge clk);
    #1;
    cpu_valid = 1'b0;
    observe({31'b0, force_trap});

    // Blink: red toggles every 16 cycles with a 4-bit counter
    repeat (15) tick();
    probe("led_before_wrap", 32'd0, {29'b0, trap_led});
    tick();
    probe("led_first_wrap", 32'd4, {29'b0, trap_led});
    repeat (15) tick();
    probe("led_hold_on", 32'd4, {29'b0, trap_led});
    tick();
    probe("led_second_wrap", 32'd0, {29'b0, trap_led});
    repeat (16) tick();
    probe("led_third_wrap", 32'd4, {29'b0, trap_led});
    rd(8'h09, 32'h03, "fw_status");
    rd(8'h0a, 32'hd0000004, "fw_viol_addr");
    rd(8'h0b, 32'd1, "fw_viol_count");
    probe("trap_sticky", 32'd1, {31'b0, force_trap});
    probe("led_before_reset", 32'd4, {29'b0, trap_led});

    // Reset mid-trap, then violate on the very first cycle after release
    reset_n = 1'b0;
    tick();
    probe("midreset_force_trap", 32'd0, {31'b0, force_trap});
    probe("midreset_trap_led", 32'd0, {29'b0, trap_led});
    reset_n = 1'b1;
    cpu(1'b0, 1'b1, 32'h40020000, 1'b1, "ram_oob_first_cycle");
    rd(8'h09, 32'h05, "ram_oob_status");
    rd(8'h0a, 32'h40020000, "ram_oob_viol_addr");

    do_reset();
    rd(8'h09, 32'd0, "status_cleared");
    cpu(1'b0, 1'b0, 32'h4001ffff, 1'b0, "ram_max_offset_ok");
    cpu(1'b1, 1'b0, 32'h00000000, 1'b0, "low_addr_ok");

    // Region 2 deny-write window
    wr(8'h18, 32'h40001000);
    wr(8'h19, 32'h400010ff);
    wr(8'h1a, 32'h00000004);
    rd(8'h18, 32'h40001000, "first2");
    rd(8'h19, 32'h400010ff, "last2");
    rd(8'h1a, 32'h00000004, "perm2");
    cpu(1'b0, 1'b1, 32'h400010ff, 1'b0, "region_disabled");
    wr(8'h08, 32'h1);
    rd(8'h08, 32'h1, "ctrl_enable");
    cpu(1'b0, 1'b1, 32'h40001100, 1'b0, "write_past_last");
    cpu(1'b0, 1'b0, 32'h400010ff, 1'b0, "read_allowed");
    cpu(1'b1, 1'b0, 32'h400010ff, 1'b0, "exec_allowed");
    cpu(1'b0, 1'b1, 32'h400010ff, 1'b1, "write_at_last");
    rd(8'h09, 32'h2b, "region2_status");
    rd(8'h0a, 32'h400010ff, "region2_viol_addr");

    // Fixed rule outranks an overlapping region
    do_reset();
    wr(8'h10, 32'hd0000000); wr(8'h11, 32'hd00000ff); wr(8'h12, 32'h1);
    wr(8'h14, 32'h40000100); wr(8'h15, 32'h400001ff); wr(8'h16, 32'h2);
    wr(8'h1c, 32'h40000180); wr(8'h1d, 32'h400002ff); wr(8'h1e, 32'h2);
    wr(8'h08, 32'h1);
    cpu(1'b1, 1'b0, 32'hd0000000, 1'b1, "fw_over_region");
    cpu(1'b0, 1'b0, 32'h400001c0, 1'b1, "second_violation");
    rd(8'h09, 32'h03, "fw_priority_status");
    rd(8'h0b, 32'd2, "two_violations");

    // Overlapping regions 1 and 3: lowest index wins
    do_reset();
    wr(8'h14, 32'h40000100); wr(8'h15, 32'h400001ff); wr(8'h16, 32'h2);
    wr(8'h1c, 32'h40000180); wr(8'h1d, 32'h400002ff); wr(8'h1e, 32'h2);
    wr(8'h18, 32'h40000300); wr(8'h19, 32'h40000200); wr(8'h1a, 32'h7);
    wr(8'h08, 32'h1);
    cpu(1'b1, 1'b0, 32'h400001c0, 1'b0, "overlap_exec_allowed");
    cpu(1'b0, 1'b1, 32'h40000250, 1'b0, "inverted_region");
    cpu(1'b0, 1'b0, 32'h400001c0, 1'b1, "overlap_read");
    rd(8'h09, 32'h19, "overlap_status");
    cpu(1'b0, 1'b0, 32'h40000280, 1'b1, "region3_read");
    rd(8'h09, 32'h19, "status_not_overwritten");
    rd(8'h0a, 32'h400001c0, "overlap_viol_addr");
    rd(8'h0b, 32'd2, "overlap_count");

    // Region write and access in the same cycle: new PERM applies next cycle
    do_reset();
    wr(8'h10, 32'h40000000); wr(8'h11, 32'h40000fff);
    wr(8'h08, 32'h1);
    expect_val("samecycle_old_perm", 32'd0);
    expect_val("samecycle_new_perm", 32'd1);
    cs = 1'b1; we = 1'b1; address = 8'h12; write_data = 32'h2;
    cpu_valid = 1'b1; cpu_instr = 1'b0; cpu_write = 1'b0; cpu_addr = 32'h40000010;
    tick();
    cs = 1'b0; we = 1'b0;
    observe({31'b0, force_trap});
    tick();
    cpu_valid = 1'b0;
    observe({31'b0, force_trap});
    rd(8'h09, 32'h09, "samecycle_status");

    // CTRL is set-only; lock freezes CTRL and region registers
    do_reset();
    wr(8'h08, 32'h1);
    wr(8'h08, 32'h0);
    rd(8'h08, 32'h1, "ctrl_set_only");
    wr(8'h10, 32'haaaa0000);
    rd(8'h10, 32'haaaa0000, "first0_unlocked");
    wr(8'h08, 32'h2);
    rd(8'h08, 32'h3, "ctrl_locked");
    wr(8'h10, 32'h12345678);
    rd(8'h10, 32'haaaa0000, "first0_locked");
    wr(8'h12, 32'h7);
    rd(8'h12, 32'h0, "perm0_locked");
    wr(8'h08, 32'h0);
    rd(8'h08, 32'h3, "ctrl_write_locked");

    // Saturating violation counter; capture keeps the first violation
    do_reset();
    cs = 1'b1; we = 1'b0; address = 8'h0b;
    cpu_valid = 1'b1; cpu_instr = 1'b1; cpu_write = 1'b0; cpu_addr = 32'hd0000010;
    tick();
    cpu_instr = 1'b0; cpu_addr = 32'h40030000;
    repeat (32'hfffd) tick();
    probe("count_fffe", 32'h0000fffe, read_data);
    tick();
    probe("count_ffff", 32'h0000ffff, read_data);
    repeat (6) tick();
    probe("count_saturated", 32'h0000ffff, read_data);
    cpu_valid = 1'b0; cs = 1'b0;
    rd(8'h09, 32'h03, "sat_status");
    rd(8'h0a, 32'hd0000010, "sat_viol_addr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tk1_sec_mon.md
TK1_SEC_MON -- requirements
Module: tk1_sec_mon

Interface
REQ-001 Parameter NUM_REGIONS, default 4, number of programmable monitor regions, legal range 1..8.
REQ-002 Parameter BLINK_WIDTH, default 24, width of the trap-LED blink counter.
REQ-003 Parameter RAM_MAX_OFFSET, default 32'h0001ffff, highest legal offset in the 0x4xxxxxxx RAM window.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 cpu_valid  in  1  CPU bus access valid this cycle.
REQ-007 cpu_instr  in  1  access is an instruction fetch.
REQ-008 cpu_write  in  1  access is a data write; ignored when cpu_instr=1.
REQ-009 cpu_addr  in  32  CPU access address.
REQ-010 force_trap  out  1  sticky trap request to the CPU.
REQ-011 trap_led  out  3  {r,g,b} LED value while trapped, else 0.
REQ-012 cs, we  in  1 each  register-bus select and write strobe.
REQ-013 address  in  8  register word address.
REQ-014 write_data  in  32  register write data.
REQ-015 read_data  out  32  register read data, combinational.
REQ-016 ready  out  1  equals cs, same cycle.

Function
REQ-017 Register map: 0x00 NAME0 "tk1 "; 0x01 NAME1 "smon"; 0x02 VERSION 1; 0x08 CTRL (bit0 enable, bit1 lock); 0x09 STATUS; 0x0a VIOL_ADDR; 0x0b VIOL_COUNT; region i at 0x10+4i FIRST, 0x11+4i LAST, 0x12+4i PERM (bit0 deny exec, bit1 deny read, bit2 deny write).
REQ-018 Reads of unmapped addresses, and of region slots i>=NUM_REGIONS, return 0; writes to these addresses are ignored.
REQ-019 CTRL bits are set-only: writing 1 sets a bit; writing 0 has no effect.
REQ-020 While lock=1, writes to CTRL and to all region registers are ignored.
REQ-021 Region i matches when first_i <= cpu_addr <= last_i, unsigned and inclusive; a region with first>last never matches.
REQ-022 A cycle violates when cpu_valid=1 and any rule below holds. Fixed rules always apply; region rules apply only when enable=1.
  - cause 1: exec in 0xd0000000..0xd00007ff.
  - cause 2: cpu_addr[31:30]=01 and cpu_addr[29:0] > RAM_MAX_OFFSET.
  - cause 3/4/5: region match with exec/read/write denied for the access type.
REQ-023 Priority: cause 1 > cause 2 > region causes. Among regions, the lowest index wins.
REQ-024 force_trap rises on the clock edge after the first violating cycle (1-cycle latency) and stays high until reset.
REQ-025 On the first violation only, capture into STATUS and VIOL_ADDR:
  - STATUS[0]=1
  - STATUS[3:1]=cause
  - STATUS[7:4]=region index (0 for fixed causes)
  - VIOL_ADDR=cpu_addr
  Later violations do not overwrite these fields.
REQ-026 VIOL_COUNT[15:0] increments once per violating cycle and saturates at 0xffff.
REQ-027 While force_trap=1, the BLINK_WIDTH counter free-runs. Each time it wraps to 0, red toggles; trap_led={red,0,0}. While force_trap=0, the counter holds 0 and trap_led=0.
REQ-028 A register write and a violation in the same cycle both take effect. A region write takes effect for checks starting the next cycle.

Reset
REQ-029 On reset_n=0 at a clock edge:
  - force_trap=0, trap_led=0, red=0, blink counter=0
  - CTRL=0, STATUS=0, VIOL_ADDR=0, VIOL_COUNT=0
  - all FIRST/LAST/PERM=0
REQ-030 Reset asserted mid-trap clears the trap and all capture state. The first valid cycle after reset is checked.

Structure
REQ-031 A shared package tk1_sec_mon_pkg holds:
  - register address constants
  - cause codes
  - NAME/VERSION constants
  - FW-RAM bounds
REQ-032 One sub-module, tk1_sec_mon_region, is instantiated NUM_REGIONS times. It holds FIRST/LAST/PERM and outputs match and per-type deny.

Verification
REQ-033 Exec fetch at 0xd0000004 -> force_trap=1 next cycle; STATUS=0x03; VIOL_ADDR=0xd0000004; VIOL_COUNT=1.
REQ-034 Region 2 set to 0x40001000..0x400010ff with PERM=4, enable=1; write to 0x400010ff -> STATUS=0x2b; write to 0x40001100 -> no trap.
REQ-035 Lock=1, then write FIRST0 -> FIRST0 unchanged on readback; writing CTRL=0 leaves CTRL=3.
REQ-036 Regions 1 and 3 overlap, both deny read; read in the overlap -> STATUS[7:4]=1. A fetch to 0xd0000000 in the same setup reports cause 1.
REQ-037 BLINK_WIDTH=4, trap forced -> trap_led toggles between 3'b100 and 0 every 16 cycles; reset mid-trap -> force_trap=0 and trap_led=0 next cycle.
REQ-038 Hold violating accesses for 0x10005 cycles -> VIOL_COUNT=0xffff; STATUS and VIOL_ADDR keep the first-violation values.
